// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard-control slice: forwarding selects, FSM states, stall decode.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t STALL = 1'b1;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic piprcon;
    logic pcnoch;
    logic ifidnoch;
    logic ifid_flush;
  } stall_ctl_t;

endpackage

// File: rtl/fwd_mux_sel.sv
// Per-source EX-stage forwarding select; EX/MEM wins over MEM/WB, x0 never forwards.
module fwd_mux_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  output logic [1:0]        sel
);

  logic nz;
  assign nz = (rs != REG_AW'(REG_ZERO));

  always_comb begin
    sel = FWD_RF;
    if (nz && exmem_regwrite && exmem_rd == rs)      sel = FWD_MEM;
    else if (nz && memwb_regwrite && memwb_rd == rs) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall FSM, branch flush, forwarding selects and saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MEMR_W   = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEMR_W-1:0]         idex_memr,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_rs,
  input  logic [NUM_SRC-1:0]        ifid_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic                      memwb_regwrite,
  input  logic                      branch_taken,
  output logic                      piprcon,
  output logic                      pcnoch,
  output logic                      ifidnoch,
  output logic                      ifid_flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_active,
  output logic [CNT_W-1:0]          stall_cnt
);

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       raw_haz;
  stall_ctl_t ctl;

  logic [NUM_SRC-1:0][1:0] sel_w;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_mux_sel #(.REG_AW(REG_AW)) u_fwd (
      .rs             (idex_rs[i*REG_AW +: REG_AW]),
      .exmem_rd       (exmem_rd),
      .exmem_regwrite (exmem_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_regwrite (memwb_regwrite),
      .sel            (sel_w[i])
    );
  end

  assign fwd_sel = rst_n ? sel_w : '0;

  always_comb begin
    raw_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (ifid_rs_used[i] && ifid_rs[i*REG_AW +: REG_AW] == idex_rd) raw_haz = 1'b1;
    if (idex_memr == '0 || idex_rd == REG_AW'(REG_ZERO)) raw_haz = 1'b0;
  end

  // Flush outranks any stall: the dependent instruction is being squashed anyway.
  always_comb begin
    ctl       = '0;
    state_nxt = state;
    rem_nxt   = rem;
    if (!rst_n) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
    end else if (branch_taken) begin
      ctl.ifid_flush = 1'b1;
      ctl.piprcon    = 1'b1;
      state_nxt      = IDLE;
      rem_nxt        = '0;
    end else if (state == STALL) begin
      ctl.piprcon  = 1'b1;
      ctl.pcnoch   = 1'b1;
      ctl.ifidnoch = 1'b1;
      rem_nxt      = rem - 4'd1;
      if (rem == 4'd1) state_nxt = IDLE;
    end else if (raw_haz) begin
      ctl.piprcon  = 1'b1;
      ctl.pcnoch   = 1'b1;
      ctl.ifidnoch = 1'b1;
      if (LOAD_LAT > 1) begin
        state_nxt = STALL;
        rem_nxt   = 4'(LOAD_LAT - 1);
      end
    end
  end

  assign piprcon      = ctl.piprcon;
  assign pcnoch       = ctl.pcnoch;
  assign ifidnoch     = ctl.ifidnoch;
  assign ifid_flush   = ctl.ifid_flush;
  assign stall_active = (state == STALL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (ctl.pcnoch && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three configurations (LOAD_LAT=1, LOAD_LAT=3, LOAD_LAT=3 with 4-bit counter) on shared inputs.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] idex_memr;
  logic [4:0] idex_rd;
  logic [9:0] ifid_rs;
  logic [1:0] ifid_rs_used;
  logic [9:0] idex_rs;
  logic [4:0] exmem_rd, memwb_rd;
  logic       exmem_regwrite, memwb_regwrite, branch_taken;

  logic        d1_pip, d1_pcn, d1_ifn, d1_fl, d1_sa;
  logic [3:0]  d1_fwd;
  logic [15:0] d1_cnt;
  logic        d3_pip, d3_pcn, d3_ifn, d3_fl, d3_sa;
  logic [3:0]  d3_fwd;
  logic [15:0] d3_cnt;
  logic        d4_pip, d4_pcn, d4_ifn, d4_fl, d4_sa;
  logic [3:0]  d4_fwd;
  logic [3:0]  d4_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .idex_memr(idex_memr), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used), .idex_rs(idex_rs),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken),
    .piprcon(d1_pip), .pcnoch(d1_pcn), .ifidnoch(d1_ifn), .ifid_flush(d1_fl),
    .fwd_sel(d1_fwd), .stall_active(d1_sa), .stall_cnt(d1_cnt));

  hazard_ctrl #(.LOAD_LAT(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .idex_memr(idex_memr), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used), .idex_rs(idex_rs),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken),
    .piprcon(d3_pip), .pcnoch(d3_pcn), .ifidnoch(d3_ifn), .ifid_flush(d3_fl),
    .fwd_sel(d3_fwd), .stall_active(d3_sa), .stall_cnt(d3_cnt));

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .idex_memr(idex_memr), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used), .idex_rs(idex_rs),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken),
    .piprcon(d4_pip), .pcnoch(d4_pcn), .ifidnoch(d4_ifn), .ifid_flush(d4_fl),
    .fwd_sel(d4_fwd), .stall_active(d4_sa), .stall_cnt(d4_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hazard(input logic on);
    idex_memr    = on ? 2'b01 : 2'b00;
    idex_rd      = 5'd5;
    ifid_rs      = {5'd5, 5'd3};
    ifid_rs_used = 2'b11;
  endtask

  initial begin
    rst_n = 1'b0; idex_memr = '0; idex_rd = '0; ifid_rs = '0; ifid_rs_used = '0;
    idex_rs = '0; exmem_rd = '0; memwb_rd = '0; exmem_regwrite = 1'b0;
    memwb_regwrite = 1'b0; branch_taken = 1'b0;

    // reset: outputs gated even with live hazard/forward inputs
    tick(); tick();
    hazard(1'b1);
    exmem_rd = 5'd7; exmem_regwrite = 1'b1; idex_rs = {5'd0, 5'd7};
    #1;
    chk("rst_pcnoch", d1_pcn, 0);
    chk("rst_piprcon", d3_pip, 0);
    chk("rst_fwd", d1_fwd, 0);
    chk("rst_cnt", d3_cnt, 0);
    chk("rst_sa", d3_sa, 0);
    hazard(1'b0); exmem_regwrite = 1'b0; idex_rs = '0;
    rst_n = 1'b1;
    tick();

    // load-use, LOAD_LAT=1 and 3
    hazard(1'b1);
    #1;
    chk("lu_c1_d1_stall", {d1_pip, d1_pcn, d1_ifn}, 3'b111);
    chk("lu_c1_d3_stall", {d3_pip, d3_pcn, d3_ifn}, 3'b111);
    chk("lu_c1_d3_sa", d3_sa, 0);
    tick();
    hazard(1'b0);
    #1;
    chk("lu_c2_d1_stall", {d1_pip, d1_pcn, d1_ifn}, 3'b000);
    chk("lu_c2_d1_cnt", d1_cnt, 1);
    chk("lu_c2_d3_stall", {d3_pip, d3_pcn, d3_ifn}, 3'b111);
    chk("lu_c2_d3_sa", d3_sa, 1);
    tick();
    chk("lu_c3_d3_stall", {d3_pip, d3_pcn, d3_ifn}, 3'b111);
    chk("lu_c3_d3_sa", d3_sa, 1);
    chk("lu_c3_d3_cnt", d3_cnt, 2);
    tick();
    chk("lu_c4_d3_stall", {d3_pip, d3_pcn, d3_ifn}, 3'b000);
    chk("lu_c4_d3_sa", d3_sa, 0);
    chk("lu_c4_d3_cnt", d3_cnt, 3);
    chk("lu_c4_d1_cnt", d1_cnt, 1);

    // no-hazard cases
    hazard(1'b1); idex_rd = 5'd0; ifid_rs = '0;
    #1;
    chk("nh_x0", {d1_pip, d1_pcn, d1_ifn, d3_pcn}, 4'b0000);
    hazard(1'b1); ifid_rs_used = 2'b01;
    #1;
    chk("nh_unused", {d1_pip, d1_pcn, d1_ifn, d3_pcn}, 4'b0000);
    hazard(1'b1); idex_memr = 2'b00;
    #1;
    chk("nh_noload", {d1_pcn, d3_pcn}, 2'b00);

    // flush priority over raw hazard in IDLE
    hazard(1'b1); branch_taken = 1'b1;
    #1;
    chk("fl_idle_d1", {d1_fl, d1_pip, d1_pcn, d1_ifn}, 4'b1100);
    branch_taken = 1'b0; hazard(1'b0);
    #1;

    // flush in second stall cycle, LOAD_LAT=3
    hazard(1'b1);
    tick();
    hazard(1'b0); branch_taken = 1'b1;
    #1;
    chk("fl_stall_d3", {d3_fl, d3_pip, d3_pcn, d3_ifn}, 4'b1100);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("fl_after_sa", d3_sa, 0);
    chk("fl_after_pcn", d3_pcn, 0);
    chk("fl_after_cnt", d3_cnt, 4);
    chk("fl_after_d1cnt", d1_cnt, 2);

    // forwarding priority
    exmem_rd = 5'd7; memwb_rd = 5'd7; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    idex_rs = {5'd0, 5'd7};
    #1;
    chk("fw_mem", d1_fwd, 4'b0010);
    exmem_regwrite = 1'b0;
    #1;
    chk("fw_wb", d1_fwd, 4'b0001);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = '0;
    #1;
    chk("fw_x0", d1_fwd, 4'b0000);
    exmem_rd = 5'd9; memwb_rd = 5'd7; idex_rs = {5'd7, 5'd9};
    #1;
    chk("fw_mixed", d3_fwd, 4'b0110);
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

    // saturation: 20 back-to-back stall cycles
    hazard(1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_d4", d4_cnt, 15);
    chk("sat_d1", d1_cnt, 22);
    chk("sat_d3", d3_cnt, 24);
    chk("sat_d3_install", d3_sa, 1);

    // reset mid-stall
    rst_n = 1'b0;
    #1;
    chk("rmid_pcn", {d1_pcn, d3_pcn, d4_pcn}, 3'b000);
    tick();
    chk("rmid_sa", d3_sa, 0);
    chk("rmid_cnt", d4_cnt, 0);
    rst_n = 1'b1; hazard(1'b0);
    #1;
    chk("rpost_idle", d3_pcn, 0);
    hazard(1'b1);
    #1;
    chk("rpost_haz", d3_pcn, 1);
    hazard(1'b0);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
